// File: rtl/logic_unit_pipe.sv
// rtl/logic_unit_pipe.sv - two-stage bitwise logic unit with accumulator and result flags
module logic_unit_pipe #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [2:0]       op,
  input  logic             in_acc,
  input  logic             acc_clr,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             zero,
  output logic             ones,
  output logic             parity
);

  localparam logic [2:0] OP_AND  = 3'b000;
  localparam logic [2:0] OP_OR   = 3'b001;
  localparam logic [2:0] OP_XOR  = 3'b010;
  localparam logic [2:0] OP_NOT  = 3'b011;
  localparam logic [2:0] OP_NAND = 3'b100;
  localparam logic [2:0] OP_NOR  = 3'b101;
  localparam logic [2:0] OP_XNOR = 3'b110;
  localparam logic [2:0] OP_ANDN = 3'b111;

  logic             s1_valid_q, s1_valid_d;
  logic [WIDTH-1:0] s1_result_q, s1_result_d;
  logic             s2_valid_q, s2_valid_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic             zero_q, zero_d;
  logic             ones_q, ones_d;
  logic             parity_q, parity_d;
  logic [WIDTH-1:0] acc_q, acc_d;

  logic             s2_adv;
  logic             s1_adv;
  logic             accept;
  logic [WIDTH-1:0] opnd_b;
  logic [WIDTH-1:0] calc;

  assign s2_adv = !s2_valid_q || out_ready;
  assign s1_adv = !s1_valid_q || s2_adv;
  // rst_n gating keeps in_ready low for the whole reset window
  assign in_ready = s1_adv && rst_n;
  assign accept   = in_valid && in_ready;
  assign opnd_b   = in_acc ? acc_q : b;

  always_comb begin
    calc = '0;
    case (op)
      OP_AND:  calc = a & opnd_b;
      OP_OR:   calc = a | opnd_b;
      OP_XOR:  calc = a ^ opnd_b;
      OP_NOT:  calc = ~a;
      OP_NAND: calc = ~(a & opnd_b);
      OP_NOR:  calc = ~(a | opnd_b);
      OP_XNOR: calc = ~(a ^ opnd_b);
      OP_ANDN: calc = a & ~opnd_b;
      default: calc = '0;
    endcase
  end

  always_comb begin
    s1_valid_d  = s1_valid_q;
    s1_result_d = s1_result_q;
    s2_valid_d  = s2_valid_q;
    result_d    = result_q;
    zero_d      = zero_q;
    ones_d      = ones_q;
    parity_d    = parity_q;
    acc_d       = acc_q;

    if (s1_adv) begin
      s1_valid_d = accept;
      if (accept) begin
        s1_result_d = calc;
      end
    end

    // result and flags only change together so the flags always match result
    if (s2_adv) begin
      s2_valid_d = s1_valid_q;
      if (s1_valid_q) begin
        result_d = s1_result_q;
        zero_d   = ~|s1_result_q;
        ones_d   = &s1_result_q;
        parity_d = ^s1_result_q;
      end
    end

    if (accept) begin
      acc_d = calc;
    end
    if (acc_clr) begin
      acc_d = '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid_q  <= 1'b0;
      s1_result_q <= '0;
      s2_valid_q  <= 1'b0;
      result_q    <= '0;
      zero_q      <= 1'b0;
      ones_q      <= 1'b0;
      parity_q    <= 1'b0;
      acc_q       <= '0;
    end else begin
      s1_valid_q  <= s1_valid_d;
      s1_result_q <= s1_result_d;
      s2_valid_q  <= s2_valid_d;
      result_q    <= result_d;
      zero_q      <= zero_d;
      ones_q      <= ones_d;
      parity_q    <= parity_d;
      acc_q       <= acc_d;
    end
  end

  assign out_valid = s2_valid_q;
  assign result    = result_q;
  assign zero      = zero_q;
  assign ones      = ones_q;
  assign parity    = parity_q;

endmodule

// File: tb/tb_logic_unit_pipe.sv
// tb/tb_logic_unit_pipe.sv - scoreboard bench for logic_unit_pipe with directed vectors
module tb_logic_unit_pipe;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] a;
  logic [7:0] b;
  logic [2:0] op;
  logic       in_acc;
  logic       acc_clr;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] result;
  logic       zero;
  logic       ones;
  logic       parity;

  logic_unit_pipe #(.WIDTH(8)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .op(op), .in_acc(in_acc), .acc_clr(acc_clr),
    .out_valid(out_valid), .out_ready(out_ready), .result(result),
    .zero(zero), .ones(ones), .parity(parity)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [10:0] v;
    int          cyc;
    bit          chk_lat;
  } sb_t;

  sb_t  q[$];
  int   n_checks = 0;
  int   n_fail   = 0;
  int   cyc      = 0;
  logic [10:0] nxt_exp;
  bit   nxt_lat;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at cycle %0d", name, act, exp, cyc);
    end
  endtask

  always @(negedge clk) begin : monitor
    sb_t s;
    if (rst_n && out_valid && out_ready) begin
      if (q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected_output: got result 0x%0h with empty scoreboard", result);
      end else begin
        s = q.pop_front();
        check("result_flags{r,z,o,p}", {21'd0, result, zero, ones, parity}, {21'd0, s.v});
        if (s.chk_lat) check("latency", cyc - s.cyc, 32'd2);
      end
    end
  end

  task automatic drive(input logic [2:0] o, input logic [7:0] aa, input logic [7:0] bb,
                       input logic acc, input logic clr, input logic [7:0] er,
                       input logic ez, input logic eo, input logic ep, input bit lat);
    op       = o;
    a        = aa;
    b        = bb;
    in_acc   = acc;
    acc_clr  = clr;
    in_valid = 1'b1;
    nxt_exp  = {er, ez, eo, ep};
    nxt_lat  = lat;
  endtask

  task automatic wait_accept();
    int n = 0;
    sb_t s;
    @(negedge clk);
    while (!in_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) begin
      n_checks++;
      n_fail++;
      $display("FAIL accept_timeout: in_ready stayed 0 for %0d cycles", n);
      in_valid = 1'b0;
    end else begin
      s.v = nxt_exp;
      s.cyc = cyc;
      s.chk_lat = nxt_lat;
      q.push_back(s);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    in_valid = 1'b0;
    acc_clr  = 1'b0;
    in_acc   = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    while (q.size() != 0 && n < 50) begin
      @(negedge clk);
      n++;
    end
    check("drain_queue_empty", q.size(), 32'd0);
    @(posedge clk);
    #1;
  endtask

  logic [7:0] sweep_r [8] = '{8'h30, 8'hFC, 8'hCC, 8'h0F, 8'hCF, 8'h03, 8'h33, 8'hC0};

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; a = '0; b = '0; op = '0;
    in_acc = 1'b0; acc_clr = 1'b0; out_ready = 1'b1;

    #12;
    check("reset_out_valid", {31'd0, out_valid}, 32'd0);
    check("reset_in_ready", {31'd0, in_ready}, 32'd0);
    check("reset_result_flags", {21'd0, result, zero, ones, parity}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("in_ready_after_reset", {31'd0, in_ready}, 32'd1);
    @(posedge clk);
    #1;

    // op sweep, one per cycle, fixed two-cycle latency
    for (int i = 0; i < 8; i++) begin
      drive(i[2:0], 8'hF0, 8'h3C, 1'b0, 1'b0, sweep_r[i], 1'b0, 1'b0, 1'b0, 1'b1);
      wait_accept();
    end
    idle();
    drain();

    // accumulator chaining after clear
    acc_clr = 1'b1;
    @(posedge clk);
    #1;
    acc_clr = 1'b0;
    drive(3'b010, 8'h01, 8'hEE, 1'b1, 1'b0, 8'h01, 1'b0, 1'b0, 1'b1, 1'b0);
    wait_accept();
    drive(3'b001, 8'h80, 8'h11, 1'b1, 1'b0, 8'h81, 1'b0, 1'b0, 1'b0, 1'b0);
    wait_accept();
    idle();
    drain();

    // flag extremes
    drive(3'b000, 8'hAA, 8'h55, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0);
    wait_accept();
    drive(3'b101, 8'h00, 8'h00, 1'b0, 1'b0, 8'hFF, 1'b0, 1'b1, 1'b0, 1'b0);
    wait_accept();
    idle();
    drain();

    // clear coinciding with an in_acc accept uses the old acc
    drive(3'b001, 8'h5A, 8'h00, 1'b0, 1'b0, 8'h5A, 1'b0, 1'b0, 1'b0, 1'b0);
    wait_accept();
    drive(3'b000, 8'hFF, 8'h00, 1'b1, 1'b1, 8'h5A, 1'b0, 1'b0, 1'b0, 1'b0);
    wait_accept();
    drive(3'b001, 8'h00, 8'hFF, 1'b1, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0);
    wait_accept();
    idle();
    drain();

    // backpressure: two accepted, third held off, output stable
    out_ready = 1'b0;
    drive(3'b010, 8'h12, 8'h34, 1'b0, 1'b0, 8'h26, 1'b0, 1'b0, 1'b1, 1'b0);
    wait_accept();
    drive(3'b000, 8'hFF, 8'h81, 1'b0, 1'b0, 8'h81, 1'b0, 1'b0, 1'b0, 1'b0);
    wait_accept();
    drive(3'b111, 8'hFF, 8'h0F, 1'b0, 1'b0, 8'hF0, 1'b0, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("stall_in_ready", {31'd0, in_ready}, 32'd0);
      check("stall_out_valid", {31'd0, out_valid}, 32'd1);
      check("stall_result_held", {24'd0, result}, 32'h26);
    end
    @(posedge clk);
    #1;
    out_ready = 1'b1;
    wait_accept();
    idle();
    drain();

    // reset with two ops in flight discards them and clears acc
    drive(3'b001, 8'hFF, 8'h00, 1'b0, 1'b0, 8'hFF, 1'b0, 1'b1, 1'b0, 1'b0);
    wait_accept();
    drive(3'b010, 8'h0F, 8'h00, 1'b0, 1'b0, 8'h0F, 1'b0, 1'b0, 1'b0, 1'b0);
    wait_accept();
    idle();
    rst_n = 1'b0;
    #1;
    check("async_reset_out_valid", {31'd0, out_valid}, 32'd0);
    check("async_reset_in_ready", {31'd0, in_ready}, 32'd0);
    q.delete();
    @(negedge clk);
    check("reset_mid_result_flags", {21'd0, result, zero, ones, parity}, 32'd0);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    drive(3'b001, 8'h00, 8'h77, 1'b1, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0);
    wait_accept();
    idle();
    drain();

    repeat (3) @(negedge clk);
    check("no_spurious_output", {31'd0, out_valid}, 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not complete");
    $fatal(1);
  end

endmodule
